// File: rtl/descrambler_4bits_if.sv
// rtl/descrambler_4bits_if.sv - ciphertext-in / plaintext-out stream handshake bundle
//
// C, IN_VALID, IN_READY  : ciphertext nibble stream into the descrambler
// P, OUT_VALID, OUT_READY: plaintext nibble stream out of the descrambler
// master: the surrounding logic (drives C/IN_VALID, consumes P via OUT_READY)
// slave : the descrambler itself
interface descrambler_4bits_if;
    logic [3:0] C;
    logic       IN_VALID;
    logic       IN_READY;
    logic [3:0] P;
    logic       OUT_VALID;
    logic       OUT_READY;

    modport master (
        output C, IN_VALID, OUT_READY,
        input  IN_READY, P, OUT_VALID
    );

    modport slave (
        input  C, IN_VALID, OUT_READY,
        output IN_READY, P, OUT_VALID
    );
endinterface

// File: rtl/descrambler_4bits.sv
// rtl/descrambler_4bits.sv - 4-bit LFSR keystream descrambler with one-entry output register
//
// Recovers plaintext P = C ^ K, where K is a Fibonacci LFSR (x^4+x^3+1)
// advanced once per accepted nibble.
//
// Ports:
//   CLK      clock, rising edge
//   RST_N    asynchronous active-low reset
//   LOAD     one-cycle pulse, resynchronises the keystream to SEED_IN
//   SEED_IN  new keystream state (zero is rejected and raises ERR)
//   ERR      sticky: the last LOAD carried a zero seed
//   COUNT    nibbles accepted since reset or the last LOAD (mod 256)
//   bus      stream handshakes (C/IN_VALID/IN_READY, P/OUT_VALID/OUT_READY)
module descrambler_4bits #(
    parameter logic [3:0] SEED = 4'b1001
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  LOAD,
    input  logic [3:0]            SEED_IN,
    output logic                  ERR,
    output logic [7:0]            COUNT,
    descrambler_4bits_if.slave    bus
);

    // State is exactly {ERR, OUT_VALID}, so both outputs come straight
    // from the state register.
    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_FULL  = 2'b01;
    localparam logic [1:0] ST_ERROR = 2'b10;

    logic [1:0] state_q;
    logic [1:0] state_d;
    logic [3:0] k_q;
    logic [3:0] k_next;
    logic [3:0] p_q;
    logic [7:0] count_q;
    logic       in_ready;
    logic       accept;
    logic       xfer;

    // fb = K[3]^K[2], shift left
    assign k_next = {k_q[2:0], k_q[3] ^ k_q[2]};

    // Combinational from LOAD and OUT_READY: a full register can be
    // refilled in the same cycle it drains.
    assign in_ready = !LOAD && !state_q[1] && (!state_q[0] || bus.OUT_READY);
    assign accept   = bus.IN_VALID && in_ready;
    assign xfer     = state_q[0] && bus.OUT_READY;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (accept) state_d = ST_FULL;
            ST_FULL: begin
                if (accept)    state_d = ST_FULL;
                else if (xfer) state_d = ST_EMPTY;
            end
            ST_ERROR: state_d = ST_ERROR;
            default:  state_d = ST_EMPTY;
        endcase
        // LOAD overrides everything, including a pending output.
        if (LOAD) state_d = (SEED_IN != 4'd0) ? ST_EMPTY : ST_ERROR;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_EMPTY;
            k_q     <= SEED;
            p_q     <= 4'd0;
            count_q <= 8'd0;
        end else begin
            state_q <= state_d;
            if (LOAD) begin
                count_q <= 8'd0;
                // A zero seed would lock the LFSR, so K is left alone.
                if (SEED_IN != 4'd0) k_q <= SEED_IN;
            end else if (accept) begin
                p_q     <= bus.C ^ k_q;
                k_q     <= k_next;
                count_q <= count_q + 8'd1;
            end
        end
    end

    assign bus.IN_READY  = in_ready;
    assign bus.P         = p_q;
    assign bus.OUT_VALID = state_q[0];
    assign ERR           = state_q[1];
    assign COUNT         = count_q;

endmodule

// File: tb/tb_descrambler_4bits.sv
// tb/tb_descrambler_4bits.sv - scoreboard testbench for descrambler_4bits
module tb_descrambler_4bits;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       LOAD = 1'b0;
    logic [3:0] SEED_IN = 4'd0;
    logic       ERR;
    logic [7:0] COUNT;

    descrambler_4bits_if bus ();

    descrambler_4bits #(.SEED(4'b1001)) dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .LOAD    (LOAD),
        .SEED_IN (SEED_IN),
        .ERR     (ERR),
        .COUNT   (COUNT),
        .bus     (bus)
    );

    always #5 CLK = ~CLK;

    int pass_cnt = 0;
    int total_cnt = 0;

    // reference model state
    logic [3:0] m_k;
    logic       m_ov;
    logic       m_err;
    int         m_count;
    int         acc_total;
    logic [3:0] exp_q[$];
    logic [3:0] seen[$];

    task automatic chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d required %0d", name, act, exp);
    endtask

    // x^4+x^3+1: new LSB is bit3 xor bit2, rest shift up
    function automatic logic [3:0] lfsr_next(input logic [3:0] k);
        int v;
        v = (int'(k) * 2) % 16;
        v = v + ((int'(k) / 8) ^ ((int'(k) / 4) % 2));
        return v[3:0];
    endfunction

    // Monitor: every output transfer pops one expected nibble.
    always @(negedge CLK) begin
        if (RST_N && bus.OUT_VALID && bus.OUT_READY) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_p", 1, 0);
            end else begin
                chk("p", int'(bus.P), int'(exp_q.pop_front()));
                seen.push_back(bus.P);
            end
        end
    end

    task automatic do_reset();
        RST_N = 1'b0;
        #1;
        chk("rst_p", int'(bus.P), 0);
        chk("rst_ov", int'(bus.OUT_VALID), 0);
        chk("rst_count", int'(COUNT), 0);
        chk("rst_err", int'(ERR), 0);
        m_k = 4'b1001; m_ov = 1'b0; m_err = 1'b0; m_count = 0; acc_total = 0;
        exp_q.delete();
        @(posedge CLK); #1;
        RST_N = 1'b1;
        #1;
        chk("rst_in_ready", int'(bus.IN_READY), 1);
    endtask

    // Apply inputs for one cycle, check registered state and IN_READY
    // against the model, then advance the model across the next edge.
    task automatic step(input logic ld, input logic [3:0] sd, input logic [3:0] c,
                        input logic iv, input logic ordy);
        logic exp_ready;
        LOAD = ld; SEED_IN = sd; bus.C = c; bus.IN_VALID = iv; bus.OUT_READY = ordy;
        @(negedge CLK);
        exp_ready = !ld && !m_err && (!m_ov || ordy);
        chk("in_ready", int'(bus.IN_READY), int'(exp_ready));
        chk("out_valid", int'(bus.OUT_VALID), int'(m_ov));
        chk("err", int'(ERR), int'(m_err));
        chk("count", int'(COUNT), m_count);
        if (ld) begin
            exp_q.delete();
            m_ov = 1'b0;
            m_count = 0;
            acc_total = 0;
            if (sd != 4'd0) begin m_k = sd; m_err = 1'b0; end
            else m_err = 1'b1;
        end else if (iv && exp_ready) begin
            exp_q.push_back(c ^ m_k);
            m_k = lfsr_next(m_k);
            m_ov = 1'b1;
            m_count = (m_count + 1) % 256;
            acc_total++;
        end else if (m_ov && ordy) begin
            m_ov = 1'b0;
        end
        @(posedge CLK); #1;
    endtask

    task automatic chk_seen(input string name, input logic [3:0] ref_v[$]);
        chk({name, "_n"}, seen.size(), ref_v.size());
        for (int i = 0; i < ref_v.size() && i < seen.size(); i++)
            chk($sformatf("%s%0d", name, i), int'(seen[i]), int'(ref_v[i]));
    endtask

    initial begin
        logic [3:0] ks_ref[$];
        logic [3:0] zeros[$];
        logic [3:0] rnd_seed;
        logic       rnd_ld;
        int         guard;

        bus.C = 4'd0; bus.IN_VALID = 1'b0; bus.OUT_READY = 1'b0;
        #1;
        do_reset();

        // keystream from seed 1001
        seen.delete();
        repeat (5) step(1'b0, 4'd0, 4'd0, 1'b1, 1'b1);
        step(1'b0, 4'd0, 4'd0, 1'b0, 1'b1);
        chk("ks_count", int'(COUNT), 5);
        ks_ref = '{4'b1001, 4'b0011, 4'b0110, 4'b1101, 4'b1010};
        chk_seen("ks", ks_ref);

        // round trip over a full period plus one
        do_reset();
        seen.delete();
        for (int i = 0; i < 16; i++) step(1'b0, 4'd0, m_k, 1'b1, 1'b1);
        step(1'b0, 4'd0, 4'd0, 1'b0, 1'b1);
        chk("rt_count", int'(COUNT), 16);
        zeros.delete();
        repeat (16) zeros.push_back(4'd0);
        chk_seen("rt", zeros);

        // backpressure
        do_reset();
        seen.delete();
        step(1'b0, 4'd0, 4'd0, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 4'd0, 4'd0, 1'b1, 1'b0);
            chk("bp_hold_p", int'(bus.P), 9);
            chk("bp_hold_count", int'(COUNT), 1);
        end
        step(1'b0, 4'd0, 4'd0, 1'b1, 1'b1);
        step(1'b0, 4'd0, 4'd0, 1'b0, 1'b1);
        ks_ref = '{4'b1001, 4'b0011};
        chk_seen("bp", ks_ref);

        // zero-seed error, then recovery
        seen.delete();
        step(1'b1, 4'd0, 4'd0, 1'b0, 1'b0);
        chk("zs_err", int'(ERR), 1);
        step(1'b0, 4'd0, 4'd0, 1'b1, 1'b1);
        step(1'b1, 4'd1, 4'd0, 1'b0, 1'b0);
        chk("zs_err_clr", int'(ERR), 0);
        step(1'b0, 4'd0, 4'd0, 1'b1, 1'b1);
        step(1'b0, 4'd0, 4'd0, 1'b1, 1'b1);
        step(1'b0, 4'd0, 4'd0, 1'b0, 1'b1);
        ks_ref = '{4'b0001, 4'b0010};
        chk_seen("zs", ks_ref);

        // LOAD colliding with a pending output and a valid input
        seen.delete();
        step(1'b0, 4'd0, 4'd5, 1'b1, 1'b0);
        step(1'b1, 4'b0110, 4'd5, 1'b1, 1'b0);
        chk("col_ov", int'(bus.OUT_VALID), 0);
        step(1'b0, 4'd0, 4'd0, 1'b1, 1'b1);
        step(1'b0, 4'd0, 4'd0, 1'b0, 1'b1);
        ks_ref = '{4'b0110};
        chk_seen("col", ks_ref);

        // random traffic with occasional loads (some with zero seed)
        for (int i = 0; i < 400; i++) begin
            rnd_ld = ($urandom_range(0, 24) == 0);
            rnd_seed = 4'($urandom_range(0, 15));
            step(rnd_ld, rnd_seed, 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 3) != 0),
                 rnd_ld ? 1'b0 : 1'($urandom_range(0, 2) != 0));
        end

        // 256 accepts: counter wraps, then reset while output pending
        step(1'b1, 4'b1011, 4'd0, 1'b0, 1'b0);
        guard = 0;
        while (acc_total < 256 && guard < 3000) begin
            step(1'b0, 4'd0, 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 3) != 0));
            guard++;
        end
        chk("wrap_accepts", acc_total, 256);
        chk("wrap_count", int'(COUNT), 0);
        if (!m_ov) step(1'b0, 4'd0, 4'd0, 1'b1, 1'b1);
        chk("pre_rst_ov", int'(bus.OUT_VALID), 1);
        do_reset();
        seen.delete();
        step(1'b0, 4'd0, 4'd0, 1'b1, 1'b1);
        step(1'b0, 4'd0, 4'd0, 1'b0, 1'b1);
        ks_ref = '{4'b1001};
        chk_seen("post_rst", ks_ref);

        chk("sb_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
